// File: rtl/array_packed_3d_reader.sv
// Snapshots a packed [N1][N2][N3][DW] array on start and streams its elements (i, j, k order) over a valid/ready handshake.
// Optional running checksum output enabled by ARRAY_PACKED_3D_READER_CHECKSUM_EN.
//
// state  | meaning
// IDLE   | waiting for start, out_valid low
// STREAM | presenting snap[i][j][k], advancing on each handshake
// DONE   | one-cycle done pulse, then back to IDLE
module array_packed_3d_reader #(
  parameter  int DW  = 8,
  parameter  int N1  = 4,
  parameter  int N2  = 3,
  parameter  int N3  = 2,
  localparam int IW1 = (N1 > 1) ? $clog2(N1) : 1,
  localparam int IW2 = (N2 > 1) ? $clog2(N2) : 1,
  localparam int IW3 = (N3 > 1) ? $clog2(N3) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic [N1-1:0][N2-1:0][N3-1:0][DW-1:0]  array_i,
  output logic                                   busy,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [DW-1:0]                          out_data,
  output logic [IW1-1:0]                         out_i,
  output logic [IW2-1:0]                         out_j,
  output logic [IW3-1:0]                         out_k,
  output logic                                   out_last,
`ifdef ARRAY_PACKED_3D_READER_CHECKSUM_EN
  output logic [DW+7:0]                          checksum,
`endif
  output logic                                   done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]                                  state_q, state_d;
  logic [N1-1:0][N2-1:0][N3-1:0][DW-1:0]       snap_q, snap_d;
  logic [IW1-1:0]                              i_q, i_d;
  logic [IW2-1:0]                              j_q, j_d;
  logic [IW3-1:0]                              k_q, k_d;
  logic                                        at_last;

  assign at_last = (i_q == IW1'(N1 - 1)) && (j_q == IW2'(N2 - 1)) && (k_q == IW3'(N3 - 1));

  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_STREAM);
  assign out_last  = out_valid && at_last;
  assign done      = (state_q == S_DONE);
  assign out_data  = snap_q[i_q][j_q][k_q];
  assign out_i     = i_q;
  assign out_j     = j_q;
  assign out_k     = k_q;

`ifdef ARRAY_PACKED_3D_READER_CHECKSUM_EN
  logic [DW+7:0] sum_q, sum_d;
  assign checksum = sum_q;
`endif

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
`ifdef ARRAY_PACKED_3D_READER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_d  = array_i;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
`ifdef ARRAY_PACKED_3D_READER_CHECKSUM_EN
          sum_d   = '0;
`endif
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (out_ready) begin
`ifdef ARRAY_PACKED_3D_READER_CHECKSUM_EN
          sum_d = sum_q + {8'd0, out_data};
`endif
          if (at_last) begin
            // Park the counters at the origin so idle indices read as zero.
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            state_d = S_DONE;
          end else if (k_q != IW3'(N3 - 1)) begin
            k_d = k_q + 1'b1;
          end else begin
            k_d = '0;
            if (j_q != IW2'(N2 - 1)) begin
              j_d = j_q + 1'b1;
            end else begin
              j_d = '0;
              i_d = i_q + 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      snap_q  <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end

`ifdef ARRAY_PACKED_3D_READER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end
`endif

endmodule

// File: tb/tb_array_packed_3d_reader.sv
// Directed bench for array_packed_3d_reader: scoreboard of expected elements, immediate-assertion checks.
module tb_array_packed_3d_reader;

  localparam int DW = 8;
  localparam int N1 = 4;
  localparam int N2 = 3;
  localparam int N3 = 2;
  localparam int NE = N1 * N2 * N3;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] i;
    logic [1:0] j;
    logic       k;
    logic       last;
  } exp_t;

  logic                                  clk;
  logic                                  rst_n;
  logic                                  start;
  logic [N1-1:0][N2-1:0][N3-1:0][DW-1:0] array_i;
  logic                                  busy;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [DW-1:0]                         out_data;
  logic [1:0]                            out_i;
  logic [1:0]                            out_j;
  logic                                  out_k;
  logic                                  out_last;
  logic                                  done;
`ifdef ARRAY_PACKED_3D_READER_CHECKSUM_EN
  logic [DW+7:0]                         checksum;
`endif

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  int   sum_model;
  int   hs_cnt;

  array_packed_3d_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .array_i   (array_i),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_i     (out_i),
    .out_j     (out_j),
    .out_k     (out_k),
    .out_last  (out_last),
`ifdef ARRAY_PACKED_3D_READER_CHECKSUM_EN
    .checksum  (checksum),
`endif
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Loads i+j+k, pushes the expected stream, pulses start at a negedge.
  task automatic kick(input logic rdy);
    exp_t e;
    sb.delete();
    sum_model = 0;
    for (int i = 0; i < N1; i++)
      for (int j = 0; j < N2; j++)
        for (int k = 0; k < N3; k++) begin
          array_i[i][j][k] = 8'(i + j + k);
          e.d    = 8'(i + j + k);
          e.i    = 2'(i);
          e.j    = 2'(j);
          e.k    = 1'(k);
          e.last = (i == N1 - 1) && (j == N2 - 1) && (k == N3 - 1);
          sb.push_back(e);
        end
    out_ready = rdy;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("latency_valid", {31'd0, out_valid}, 32'd1);
    check("busy_stream", {31'd0, busy}, 32'd1);
  endtask

  // mode 0: ready held high; mode 1: random ready. stop_after>0 returns early.
  task automatic consume(input int mode, input int stop_after, input bit poke, output int hs);
    exp_t       e;
    logic       rdy;
    bit         exp_done = 1'b0;
    bit         stall    = 1'b0;
    logic [7:0] pd;
    logic [1:0] pi, pj;
    logic       pk, pl;
    hs = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      check("done_timing", {31'd0, done}, {31'd0, exp_done});
      if (exp_done) begin
`ifdef ARRAY_PACKED_3D_READER_CHECKSUM_EN
        check("checksum", 32'(checksum), 32'(sum_model));
`endif
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_once", {31'd0, done}, 32'd0);
        check("busy_after", {31'd0, busy}, 32'd0);
        check("valid_after", {31'd0, out_valid}, 32'd0);
        return;
      end
      if (stall) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_data", {24'd0, out_data}, {24'd0, pd});
        check("stall_i", {30'd0, out_i}, {30'd0, pi});
        check("stall_j", {30'd0, out_j}, {30'd0, pj});
        check("stall_k", {31'd0, out_k}, {31'd0, pk});
        check("stall_last", {31'd0, out_last}, {31'd0, pl});
      end
      rdy = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      start = (poke && hs == 5) ? 1'b1 : 1'b0;
      stall = out_valid && !rdy;
      pd = out_data; pi = out_i; pj = out_j; pk = out_k; pl = out_last;
      if (out_valid && rdy) begin
        if (sb.size() == 0) begin
          check("extra_handshake", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check("data", {24'd0, out_data}, {24'd0, e.d});
          check("idx_i", {30'd0, out_i}, {30'd0, e.i});
          check("idx_j", {30'd0, out_j}, {30'd0, e.j});
          check("idx_k", {31'd0, out_k}, {31'd0, e.k});
          check("last", {31'd0, out_last}, {31'd0, e.last});
          sum_model += int'(e.d);
          exp_done = e.last;
          hs++;
        end
      end
      if (stop_after > 0 && hs == stop_after) return;
      @(negedge clk);
      start = 1'b0;
    end
    check("timeout_handshakes", hs, NE);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    array_i   = '0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_last", {31'd0, out_last}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_data", {24'd0, out_data}, 32'd0);
    check("rst_idx", {27'd0, out_i, out_j, out_k}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("busy_after_release", {31'd0, busy}, 32'd0);

    // Full stream; ready already high on the start edge.
    kick(1'b1);
    consume(0, 0, 1'b0, hs_cnt);
    check("full_handshakes", hs_cnt, NE);
    check("full_checksum_model", sum_model, 72);

    // Backpressure with snapshot isolation.
    kick(1'b0);
    array_i = '1;
    consume(1, 0, 1'b0, hs_cnt);
    check("bp_handshakes", hs_cnt, NE);
    check("bp_queue_empty", sb.size(), 0);

    // Start pulses mid-stream and in the DONE cycle.
    kick(1'b1);
    consume(0, 0, 1'b1, hs_cnt);
    check("poke_handshakes", hs_cnt, NE);
    repeat (2) begin
      @(negedge clk);
      check("poke_no_restart", {31'd0, busy}, 32'd0);
    end

    // Reset after handshake 10.
    kick(1'b1);
    consume(0, 10, 1'b0, hs_cnt);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_data", {24'd0, out_data}, 32'd0);
    check("mid_rst_idx", {27'd0, out_i, out_j, out_k}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_no_done", {30'd0, done, busy}, 32'd0);
    end
    kick(1'b1);
    consume(0, 0, 1'b0, hs_cnt);
    check("restart_handshakes", hs_cnt, NE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
